// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational instruction-memory read port between two requesters.
// Define IMEM_ARB_CHECK_EN to flag misaligned or out-of-range reads (data forced to zero on error).
module imem_fetch_arbiter #(
  parameter int unsigned DEPTH = 201
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data0,
  output logic [31:0] rsp_data1,
  output logic [1:0]  rsp_err,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] mem_a,
  input  logic [31:0] mem_rd
);

  logic        last_grant_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data_q [2];
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        addr_err;
  logic [31:0] load_data;

  // A full buffer can still accept when it is being drained this cycle.
  always_comb begin
    elig = '0;
    for (int p = 0; p < 2; p++) begin
      elig[p] = reset & req_valid[p] & (~rsp_valid_q[p] | rsp_ready[p]);
    end
  end

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  assign req_ready = grant;
  assign mem_a     = grant[1] ? req_addr1 : req_addr0;

`ifdef IMEM_ARB_CHECK_EN
  logic [1:0] rsp_err_q;

  always_comb begin
    addr_err  = (mem_a[1:0] != 2'b00) || ({2'b00, mem_a[31:2]} >= DEPTH);
    load_data = addr_err ? 32'h0 : mem_rd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (grant[p]) rsp_err_q[p] <= addr_err;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  always_comb begin
    addr_err  = 1'b0;
    load_data = mem_rd;
  end

  assign rsp_err = 2'b00;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q  <= 1'b1;
      rsp_valid_q   <= 2'b00;
      rsp_data_q[0] <= 32'h0;
      rsp_data_q[1] <= 32'h0;
    end else begin
      if (|grant) last_grant_q <= grant[1];
      for (int p = 0; p < 2; p++) begin
        if (grant[p]) begin
          rsp_valid_q[p] <= 1'b1;
          rsp_data_q[p]  <= load_data;
        end else if (rsp_ready[p]) begin
          rsp_valid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data0 = rsp_data_q[0];
  assign rsp_data1 = rsp_data_q[1];

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed self-checking bench for imem_fetch_arbiter with a combinational memory model.
module tb_imem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data0;
  logic [31:0] rsp_data1;
  logic [1:0]  rsp_err;
  logic [1:0]  rsp_ready;
  logic [31:0] mem_a;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  imem_fetch_arbiter #(.DEPTH(201)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data0 (rsp_data0),
    .rsp_data1 (rsp_data1),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .mem_a     (mem_a),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [29:0] idx);
    return 32'h1000_0000 + {2'b00, idx} * 32'h11;
  endfunction

  always_comb mem_rd = word_of(mem_a[31:2]);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
    req_addr0 = 32'd0; req_addr1 = 32'd4;
    step(); step();
    checks++; if (req_ready !== 2'b00) begin errors++;
      $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++;
      $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_data0 !== 32'h0 || rsp_data1 !== 32'h0) begin errors++;
      $display("FAIL reset_rsp_data: got %h/%h expected 0/0", rsp_data0, rsp_data1); end
    checks++; if (rsp_err !== 2'b00) begin errors++;
      $display("FAIL reset_rsp_err: got %b expected 00", rsp_err); end
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL first_tie_grant: got %b expected 01", req_ready); end
    step();
    checks++; if (rsp_valid !== 2'b01 || rsp_data0 !== word_of(30'd0)) begin errors++;
      $display("FAIL first_rsp: got v=%b d=%h expected v=01 d=%h", rsp_valid, rsp_data0,
               word_of(30'd0)); end
    checks++; if (req_ready !== 2'b10) begin errors++;
      $display("FAIL second_tie_grant: got %b expected 10", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b10 || rsp_data1 !== word_of(30'd1)) begin errors++;
      $display("FAIL second_rsp: got v=%b d=%h expected v=10 d=%h", rsp_valid, rsp_data1,
               word_of(30'd1)); end
    step();
  endtask

  task automatic test_single_port();
    rsp_ready = 2'b11; req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      req_addr0 = 32'(4 * i);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++;
        $display("FAIL single_req_ready[%0d]: got %b expected 01", i, req_ready); end
      step();
      checks++; if (rsp_valid !== 2'b01 || rsp_data0 !== word_of(30'(i))) begin errors++;
        $display("FAIL single_rsp[%0d]: got v=%b d=%h expected v=01 d=%h", i, rsp_valid,
                 rsp_data0, word_of(30'(i))); end
    end
    req_valid = 2'b00;
    step();
    checks++; if (rsp_valid !== 2'b00) begin errors++;
      $display("FAIL single_drain: got %b expected 00", rsp_valid); end
  endtask

  // last grant before this test was port 0, so the alternation starts on port 1
  task automatic test_contention();
    int g = 1;
    int idx [2] = '{4, 8};
    rsp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      req_addr0 = 32'(4 * idx[0]);
      req_addr1 = 32'(4 * idx[1]);
      #1;
      checks++; if (req_ready !== 2'(1 << g)) begin errors++;
        $display("FAIL contention_grant[%0d]: got %b expected %b", i, req_ready, 2'(1 << g));
      end
      step();
      checks++;
      if (rsp_valid !== 2'(1 << g) ||
          (g == 0 ? rsp_data0 : rsp_data1) !== word_of(30'(idx[g]))) begin
        errors++;
        $display("FAIL contention_rsp[%0d]: got v=%b d=%h expected v=%b d=%h", i, rsp_valid,
                 g == 0 ? rsp_data0 : rsp_data1, 2'(1 << g), word_of(30'(idx[g])));
      end
      idx[g] = idx[g] + 1;
      g = 1 - g;
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 2'b01; req_valid = 2'b10; req_addr1 = 32'd40;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++;
      $display("FAIL bp_fill_grant: got %b expected 10", req_ready); end
    step();
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_addr0 = 32'(4 * i);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++;
        $display("FAIL bp_grant[%0d]: got %b expected 01", i, req_ready); end
      step();
      checks++;
      if (rsp_valid !== 2'b11 || rsp_data1 !== word_of(30'd10) ||
          rsp_data0 !== word_of(30'(i))) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d0=%h d1=%h expected v=11 d0=%h d1=%h", i,
                 rsp_valid, rsp_data0, rsp_data1, word_of(30'(i)), word_of(30'd10));
      end
    end
    rsp_ready = 2'b11; req_addr1 = 32'd44;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++;
      $display("FAIL bp_release_grant: got %b expected 10", req_ready); end
    step();
    checks++; if (rsp_valid !== 2'b10 || rsp_data1 !== word_of(30'd11)) begin errors++;
      $display("FAIL bp_reload: got v=%b d1=%h expected v=10 d1=%h", rsp_valid, rsp_data1,
               word_of(30'd11)); end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_check();
    logic [31:0] addrs [3] = '{32'd6, 32'd804, 32'd800};
    logic [1:0]  exp_err;
    logic [31:0] exp_data;
    rsp_ready = 2'b11; req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      req_addr0 = addrs[i];
`ifdef IMEM_ARB_CHECK_EN
      exp_err  = (i == 2) ? 2'b00 : 2'b01;
      exp_data = (i == 2) ? word_of(30'd200) : 32'h0;
`else
      exp_err  = 2'b00;
      exp_data = word_of(addrs[i][31:2]);
`endif
      #1;
      checks++; if (mem_a !== addrs[i]) begin errors++;
        $display("FAIL check_mem_a[%0d]: got %h expected %h", i, mem_a, addrs[i]); end
      step();
      checks++; if (rsp_err !== exp_err || rsp_data0 !== exp_data) begin errors++;
        $display("FAIL check_rsp[%0d]: got e=%b d=%h expected e=%b d=%h", i, rsp_err,
                 rsp_data0, exp_err, exp_data); end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_async_reset();
    rsp_ready = 2'b00; req_valid = 2'b11; req_addr0 = 32'd12; req_addr1 = 32'd16;
    step(); step();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b11) begin errors++;
      $display("FAIL areset_fill: got %b expected 11", rsp_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || rsp_data0 !== 32'h0 || rsp_data1 !== 32'h0) begin
      errors++;
      $display("FAIL areset_clear: got v=%b d=%h/%h expected v=00 d=0/0", rsp_valid,
               rsp_data0, rsp_data1);
    end
    step();
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL areset_first_grant: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_contention();
    test_backpressure();
    test_check();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
